// File: rtl/conv_para_gen_if.sv
// conv_para_gen_if: request/config and result bundle
// between a layer controller and conv_para_gen.
interface conv_para_gen_if #(
  parameter int TENSOR_W   = 8,
  parameter int KERNEL_W   = 4,
  parameter int CHANNELS_W = 8,
  parameter int STRIDE_W   = 4,
  parameter int KNUMS_W    = 8,
  parameter int PAD_W      = 3
);
  localparam int NW = TENSOR_W + 1;

  logic                             start;
  logic [TENSOR_W-1:0]              tensor_size;
  logic [KERNEL_W-1:0]              kernel_size;
  logic [CHANNELS_W-1:0]            channels;
  logic [STRIDE_W-1:0]              stride;
  logic [KNUMS_W-1:0]               kernel_nums;
  logic [PAD_W-1:0]                 padding;
  logic                             busy;
  logic                             done;
  logic                             err;
  logic [NW-1:0]                    out_size;
  logic [2*NW-1:0]                  col_rows;
  logic [2*KERNEL_W+CHANNELS_W-1:0] mat_cols;
  logic [2*NW+KNUMS_W-1:0]          res_num;

  modport master (
    output start, tensor_size, kernel_size, channels,
    output stride, kernel_nums, padding,
    input  busy, done, err,
    input  out_size, col_rows, mat_cols, res_num
  );

  modport slave (
    input  start, tensor_size, kernel_size, channels,
    input  stride, kernel_nums, padding,
    output busy, done, err,
    output out_size, col_rows, mat_cols, res_num
  );
endinterface

// File: rtl/conv_para_gen.sv
// conv_para_gen: latches one conv layer config and derives
// im2col/GEMM sizing values with a multi-cycle datapath.
module conv_para_gen #(
  parameter int TENSOR_W   = 8,
  parameter int KERNEL_W   = 4,
  parameter int CHANNELS_W = 8,
  parameter int STRIDE_W   = 4,
  parameter int KNUMS_W    = 8,
  parameter int PAD_W      = 3
) (
  input logic            clk,
  input logic            rst,
  conv_para_gen_if.slave bus
);
  localparam int NW   = TENSOR_W + 1;
  localparam int OOW  = 2 * NW;
  localparam int KKW  = 2 * KERNEL_W;
  localparam int MCW  = KKW + CHANNELS_W;
  localparam int RNW  = OOW + KNUMS_W;
  localparam int CNTW = $clog2(NW);

  typedef enum logic [2:0] {
    IDLE, CHECK, DIV, MUL_A, MUL_B, FIN
  } state_t;

  state_t state, state_nx;

  logic [TENSOR_W-1:0]   t_r;
  logic [KERNEL_W-1:0]   k_r;
  logic [CHANNELS_W-1:0] c_r;
  logic [STRIDE_W-1:0]   s_r;
  logic [KNUMS_W-1:0]    n_r;
  logic [PAD_W-1:0]      p_r;

  logic [NW-1:0]       quo_r;
  logic [STRIDE_W-1:0] rem_r;
  logic [CNTW-1:0]     cnt_r;
  logic [NW-1:0]       o_r;
  logic [OOW-1:0]      oo_r;
  logic [KKW-1:0]      kk_r;

  logic           err_r;
  logic [NW-1:0]  out_size_r;
  logic [OOW-1:0] col_rows_r;
  logic [MCW-1:0] mat_cols_r;
  logic [RNW-1:0] res_num_r;

  logic [NW-1:0]       span;
  logic                cfg_bad;
  logic [STRIDE_W:0]   rem_sh;
  logic                rem_ge;
  logic [NW-1:0]       o_nx;

  // config check, one restoring-division step, O = q + 1
  always_comb begin
    span    = NW'(t_r) + (NW'(p_r) << 1);
    cfg_bad = (s_r == '0) | (k_r == '0) | (NW'(k_r) > span);
    rem_sh  = {rem_r, quo_r[NW-1]};
    rem_ge  = rem_sh >= {1'b0, s_r};
    o_nx    = quo_r + NW'(1);
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and status outputs
  always_comb begin
    state_nx = state;
    bus.busy = (state != IDLE);
    bus.done = (state == FIN);
    unique case (state)
      IDLE:    if (bus.start) state_nx = CHECK;
      CHECK:   state_nx = cfg_bad ? FIN : DIV;
      DIV:     if (cnt_r == CNTW'(NW - 1)) state_nx = MUL_A;
      MUL_A:   state_nx = MUL_B;
      MUL_B:   state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // config capture, divider, multipliers, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_r        <= '0;
      k_r        <= '0;
      c_r        <= '0;
      s_r        <= '0;
      n_r        <= '0;
      p_r        <= '0;
      quo_r      <= '0;
      rem_r      <= '0;
      cnt_r      <= '0;
      o_r        <= '0;
      oo_r       <= '0;
      kk_r       <= '0;
      err_r      <= 1'b0;
      out_size_r <= '0;
      col_rows_r <= '0;
      mat_cols_r <= '0;
      res_num_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            t_r   <= bus.tensor_size;
            k_r   <= bus.kernel_size;
            c_r   <= bus.channels;
            s_r   <= bus.stride;
            n_r   <= bus.kernel_nums;
            p_r   <= bus.padding;
            err_r <= 1'b0;
          end
        end
        CHECK: begin
          if (cfg_bad) begin
            err_r      <= 1'b1;
            out_size_r <= '0;
            col_rows_r <= '0;
            mat_cols_r <= '0;
            res_num_r  <= '0;
          end else begin
            quo_r <= span - NW'(k_r);
            rem_r <= '0;
            cnt_r <= '0;
          end
        end
        DIV: begin
          quo_r <= {quo_r[NW-2:0], rem_ge};
          rem_r <= rem_ge ? STRIDE_W'(rem_sh - {1'b0, s_r})
                          : rem_sh[STRIDE_W-1:0];
          cnt_r <= cnt_r + CNTW'(1);
        end
        MUL_A: begin
          o_r  <= o_nx;
          oo_r <= OOW'(o_nx) * OOW'(o_nx);
          kk_r <= KKW'(k_r) * KKW'(k_r);
        end
        MUL_B: begin
          out_size_r <= o_r;
          col_rows_r <= oo_r;
          res_num_r  <= RNW'(oo_r) * RNW'(n_r);
          mat_cols_r <= MCW'(kk_r) * MCW'(c_r);
        end
        default: ;
      endcase
    end
  end

  assign bus.err      = err_r;
  assign bus.out_size = out_size_r;
  assign bus.col_rows = col_rows_r;
  assign bus.mat_cols = mat_cols_r;
  assign bus.res_num  = res_num_r;
endmodule

// File: tb/tb_conv_para_gen.sv
// tb_conv_para_gen: randomized and directed checks of
// conv_para_gen against an arithmetic reference model.
module tb_conv_para_gen;
  localparam int TW  = 8;
  localparam int KW  = 4;
  localparam int CW  = 8;
  localparam int SW  = 4;
  localparam int NKW = 8;
  localparam int PW  = 3;
  localparam int NW  = TW + 1;
  localparam int OOW = 2 * NW;
  localparam int MCW = 2 * KW + CW;
  localparam int RNW = OOW + NKW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_para_gen_if #(
    .TENSOR_W(TW), .KERNEL_W(KW), .CHANNELS_W(CW),
    .STRIDE_W(SW), .KNUMS_W(NKW), .PAD_W(PW)
  ) bus ();

  conv_para_gen #(
    .TENSOR_W(TW), .KERNEL_W(KW), .CHANNELS_W(CW),
    .STRIDE_W(SW), .KNUMS_W(NKW), .PAD_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int t; int k; int c; int s; int n; int p;
  } cfg_t;

  typedef struct {
    bit     err;
    longint o;
    longint rows;
    longint cols;
    longint res;
    int     lat;
  } exp_t;

  function automatic exp_t model(cfg_t g);
    exp_t e;
    int span;
    span  = g.t + 2 * g.p;
    e.err = (g.s == 0) || (g.k == 0) || (g.k > span);
    if (e.err) begin
      e.o = 0; e.rows = 0; e.cols = 0; e.res = 0;
      e.lat = 1;
    end else begin
      e.o    = (span - g.k) / g.s + 1;
      e.rows = e.o * e.o;
      e.cols = longint'(g.k) * g.k * g.c;
      e.res  = e.rows * g.n;
      e.lat  = NW + 3;
    end
    return e;
  endfunction

  function automatic logic [RNW+MCW+OOW+NW:0] pack_exp(exp_t e);
    return {e.err, NW'(e.o), OOW'(e.rows), MCW'(e.cols), RNW'(e.res)};
  endfunction

  function automatic logic [RNW+MCW+OOW+NW:0] pack_dut();
    return {bus.err, bus.out_size, bus.col_rows,
            bus.mat_cols, bus.res_num};
  endfunction

  task automatic apply(cfg_t g);
    bus.tensor_size = TW'(g.t);
    bus.kernel_size = KW'(g.k);
    bus.channels    = CW'(g.c);
    bus.stride      = SW'(g.s);
    bus.kernel_nums = NKW'(g.n);
    bus.padding     = PW'(g.p);
  endtask

  // Caller sits #1 after an edge in IDLE; returns edges from
  // the start-sampling edge until done is seen (-1 on timeout).
  task automatic do_run(input cfg_t g, output int lat,
                        output logic b1, output logic e1,
                        output logic bh);
    apply(g);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    b1  = bus.busy;
    e1  = bus.err;
    bh  = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b1) bh = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: busy/done=%b want 00",
               {bus.busy, bus.done});
    end
    checks++;
    if (pack_dut() !== '0) begin
      errors++;
      $display("FAIL reset_results: got %h want 0", pack_dut());
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input int p, input string nm);
    cfg_t g;
    exp_t e;
    int lat;
    logic b1, e1, bh;
    logic [RNW+MCW+OOW+NW:0] held;
    g = '{t:85, k:2, c:18, s:4, n:16, p:p};
    e = model(g);
    do_run(g, lat, b1, e1, bh);
    checks++;
    if (b1 !== 1'b1 || bh !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: c1=%b held=%b want 1/1", nm, b1, bh);
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s_lat: got %0d want %0d", nm, lat, e.lat);
    end
    checks++;
    if (pack_dut() !== pack_exp(e)) begin
      errors++;
      $display("FAIL %s_res: got %h want %h", nm, pack_dut(),
               pack_exp(e));
    end
    held = pack_dut();
    @(posedge clk); #1;
    checks++;
    if ({bus.done, bus.busy} !== 2'b00 || pack_dut() !== held) begin
      errors++;
      $display("FAIL %s_after: done/busy=%b res=%h want 00 %h",
               nm, {bus.done, bus.busy}, pack_dut(), held);
    end
  endtask

  task automatic test_error();
    cfg_t g[2];
    exp_t e;
    int lat;
    logic b1, e1, bh;
    g[0] = '{t:3, k:9, c:18, s:4, n:16, p:1};
    g[1] = '{t:85, k:2, c:18, s:0, n:16, p:0};
    foreach (g[j]) begin
      e = model(g[j]);
      do_run(g[j], lat, b1, e1, bh);
      checks++;
      if (lat != 1 || lat != e.lat) begin
        errors++;
        $display("FAIL err%0d_lat: got %0d want %0d", j, lat, e.lat);
      end
      checks++;
      if (pack_dut() !== pack_exp(e)) begin
        errors++;
        $display("FAIL err%0d_res: got %h want %h", j, pack_dut(),
                 pack_exp(e));
      end
      @(posedge clk); #1;
      checks++;
      if (bus.err !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL err%0d_hold: err/done=%b want 10", j,
                 {bus.err, bus.done});
      end
    end
  endtask

  task automatic test_start_ignored();
    cfg_t a, b;
    exp_t e;
    int lat, dones;
    a = '{t:85, k:2, c:18, s:4, n:16, p:0};
    b = '{t:200, k:3, c:7, s:1, n:9, p:5};
    e = model(a);
    apply(a);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    apply(b);
    lat = -1;
    dones = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 4) bus.start = 1'b1;
      if (i == 5) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (lat < 0) lat = i;
      end
    end
    checks++;
    if (dones != 1 || lat != e.lat) begin
      errors++;
      $display("FAIL ign_done: pulses=%0d lat=%0d want 1 %0d",
               dones, lat, e.lat);
    end
    checks++;
    if (pack_dut() !== pack_exp(e)) begin
      errors++;
      $display("FAIL ign_res: got %h want %h", pack_dut(),
               pack_exp(e));
    end
  endtask

  task automatic test_mid_reset();
    cfg_t g;
    exp_t e;
    int lat, dones;
    logic b1, e1, bh;
    g = '{t:85, k:2, c:18, s:4, n:16, p:1};
    e = model(g);
    apply(g);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || pack_dut() !== '0) begin
      errors++;
      $display("FAIL mrst_clear: busy/done=%b res=%h want 00 0",
               {bus.busy, bus.done}, pack_dut());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mrst_nodone: pulses=%0d want 0", dones);
    end
    do_run(g, lat, b1, e1, bh);
    checks++;
    if (lat != e.lat || pack_dut() !== pack_exp(e)) begin
      errors++;
      $display("FAIL mrst_rerun: lat=%0d res=%h want %0d %h",
               lat, pack_dut(), e.lat, pack_exp(e));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    cfg_t ge, gb, gn;
    exp_t e;
    int lat;
    logic b1, e1, bh;
    ge = '{t:3, k:9, c:18, s:4, n:16, p:1};
    gb = '{t:255, k:1, c:255, s:1, n:255, p:7};
    gn = '{t:85, k:2, c:18, s:4, n:16, p:0};
    do_run(ge, lat, b1, e1, bh);
    @(posedge clk); #1;
    e = model(gb);
    do_run(gb, lat, b1, e1, bh);
    checks++;
    if (b1 !== 1'b1 || e1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c1: busy/err=%b want 10", {b1, e1});
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL b2b_lat: got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (pack_dut() !== pack_exp(e) || bus.res_num !== RNW'(18452055)) begin
      errors++;
      $display("FAIL b2b_res: got %h want %h", pack_dut(),
               pack_exp(e));
    end
    @(posedge clk); #1;
    e = model(gn);
    do_run(gn, lat, b1, e1, bh);
    checks++;
    if (lat != e.lat || pack_dut() !== pack_exp(e)) begin
      errors++;
      $display("FAIL b2b2_run: lat=%0d res=%h want %0d %h",
               lat, pack_dut(), e.lat, pack_exp(e));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    cfg_t g;
    exp_t e;
    int lat;
    logic b1, e1, bh;
    for (int it = 0; it < 30; it++) begin
      g.t = int'($urandom_range(0, 255));
      g.k = int'($urandom_range(0, 15));
      g.c = int'($urandom_range(0, 255));
      g.s = int'($urandom_range(0, 15));
      g.n = int'($urandom_range(0, 255));
      g.p = int'($urandom_range(0, 7));
      if (it % 4 == 0) g.t = int'($urandom_range(0, 12));
      e = model(g);
      do_run(g, lat, b1, e1, bh);
      checks++;
      if (lat != e.lat || b1 !== 1'b1 || bh !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_timing: lat=%0d busy=%b%b want %0d 11",
                 it, lat, b1, bh, e.lat);
      end
      checks++;
      if (pack_dut() !== pack_exp(e)) begin
        errors++;
        $display("FAIL rnd%0d_res: T=%0d K=%0d S=%0d P=%0d got %h want %h",
                 it, g.t, g.k, g.s, g.p, pack_dut(), pack_exp(e));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    apply('{t:0, k:0, c:0, s:0, n:0, p:0});
    #1;
    test_reset();
    test_basic(0, "basic");
    test_basic(1, "pad");
    test_error();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
